axis_wave_sched: RTL and testbench
==================================

AXIS_WAVE_SCHED -- requirements
Module: axis_wave_sched

Interface
REQ-001 SHALL have parameter NFIFO, default 4, log2 of queue depth (depth 2**NFIFO).
REQ-002 SHALL have parameter BTS, default 32, timestamp and time-counter width.
REQ-003 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, pulse that clears the time counter and enters RUN.
REQ-006 SHALL have port stop, input, 1, pulse that enters IDLE.
REQ-007 SHALL have port flush, input, 1, pulse that empties the queue and drops the output register.
REQ-008 SHALL have port s_axis_tvalid/s_axis_tready, in/out, 1/1, input handshake.
REQ-009 SHALL have port s_axis_tdata, input, BTS+80, {ts[BTS-1:0], qsel[7:0], ctrl[7:0], wait[31:0], addr[31:0]}.
REQ-010 SHALL have port m_axis_tvalid/m_axis_tready, out/in, 1/1, output handshake to the signal generator waveform push port.
REQ-011 SHALL have port m_axis_tdata, output, 80, {qsel, ctrl, wait, addr}, bit-exact copy of the low 80 input bits.
REQ-012 SHALL have port time_o, output, BTS, current time counter.
REQ-013 SHALL have ports fifo_cnt_o (NFIFO+1 bits), late_cnt_o (16 bits), and busy_o (1 bit: RUN state).

Function
REQ-014 SHALL implement FSM with states IDLE and RUN; start -> RUN from either state; stop -> IDLE; start and stop in the same cycle -> IDLE (stop wins).
REQ-015 SHALL clear time_o to 0 on the cycle after start, then increment by 1 every cycle in RUN, wrapping modulo 2**BTS; time_o SHALL hold in IDLE.
REQ-016 SHALL accept input when s_axis_tready = !full; a full queue SHALL NOT pass data through even if a pop occurs the same cycle.
REQ-017 SHALL support simultaneous push and pop when not full, with fifo_cnt_o unchanged.
REQ-018 SHALL treat the head entry as due when in RUN and (time_o - ts) interpreted as signed BTS-bit is >= 0 (wrap-safe).
REQ-019 SHALL load the head into the output register at the clock edge ending the cycle in which it is due and the output register is empty or being consumed (m_axis_tvalid && m_axis_tready).
REQ-020 Minimum latency: entry with ts = T present in the queue before time_o = T SHALL produce m_axis_tvalid = 1 in the cycle time_o = T+1.
REQ-021 SHALL hold m_axis_tvalid and m_axis_tdata stable until m_axis_tready; back-to-back entries with equal ts SHALL issue on consecutive cycles under continuous tready.
REQ-022 SHALL dispatch strictly in arrival order; a not-yet-due head SHALL block later entries.
REQ-023 SHALL increment late_cnt_o (saturating at 0xFFFF) for each load into the output register while time_o != ts.
REQ-024 In IDLE SHALL NOT load new entries; a valid output register SHALL remain valid until consumed.
REQ-025 flush SHALL empty the queue and clear m_axis_tvalid in the next cycle; a push coincident with flush SHALL be discarded; time_o and state SHALL be unaffected.

Reset
REQ-026 areset SHALL, at the next aclk edge, set state IDLE, time_o 0, queue empty, fifo_cnt_o 0, late_cnt_o 0, m_axis_tvalid 0, m_axis_tdata 0, s_axis_tready 0 during reset and 1 the cycle after.
REQ-027 Reset mid-operation SHALL discard all queued and pending entries without emitting a partial transfer.

Structure
REQ-028 Package axis_wave_sched_pkg SHALL hold the 80-bit field offsets/widths, the state enum, and the late counter width.
REQ-029 The queue SHALL be a sub-module wave_sched_fifo (synchronous, depth 2**NFIFO, registered count, flush input).

Verification
REQ-030 Start, push ts=10 addr=5 -> m_axis_tvalid rises with time_o=11, tdata addr=5, late_cnt_o=0.
REQ-031 Push ts=3,3,3 while IDLE, start, tready=1 -> three transfers at time_o 4,5,6; late_cnt_o=2.
REQ-032 Fill 16 entries (NFIFO=4) in IDLE -> s_axis_tready=0, fifo_cnt_o=16; 17th held until a pop.
REQ-033 Run near wrap: start, preload counter path to 2**32-2, push ts=1 -> not dispatched before time_o=1, dispatched at time_o=2.
REQ-034 Hold tready=0 with due head, assert flush -> m_axis_tvalid=0 next cycle, fifo_cnt_o=0.
REQ-035 Assert areset while m_axis_tvalid=1 and queue holds 5 -> all outputs reset per REQ-026, no transfer observed.

Source files
------------

// File: rtl/axis_wave_sched_pkg.sv
// axis_wave_sched_pkg: shared field layout, state encoding and counter widths
package axis_wave_sched_pkg;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W = 32;
  localparam int WAIT_LSB = 32;
  localparam int WAIT_W = 32;
  localparam int CTRL_LSB = 64;
  localparam int CTRL_W = 8;
  localparam int QSEL_LSB = 72;
  localparam int QSEL_W = 8;
  localparam int OUT_W = 80;
  localparam int LATE_W = 16;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/wave_sched_fifo.sv
// wave_sched_fifo: synchronous FIFO with registered occupancy count and flush
module wave_sched_fifo #(
  parameter int NFIFO = 4,
  parameter int W = 112
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic [NFIFO:0]   cnt
);
  logic [W-1:0] mem [2**NFIFO];
  logic [NFIFO-1:0] wp, rp;
  logic wr, rd;
  assign full = cnt[NFIFO];
  assign empty = cnt == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge aclk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge aclk) begin
    if (areset || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (NFIFO+1)'(wr) - (NFIFO+1)'(rd);
    end
  end
endmodule

// File: rtl/axis_wave_sched.sv
// axis_wave_sched: releases queued waveform words when the time counter reaches their timestamp
module axis_wave_sched
  import axis_wave_sched_pkg::*;
#(
  parameter int NFIFO = 4,
  parameter int BTS = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 flush,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [BTS+OUT_W-1:0] s_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OUT_W-1:0]     m_axis_tdata,
  output logic [BTS-1:0]       time_o,
  output logic [NFIFO:0]       fifo_cnt_o,
  output logic [LATE_W-1:0]    late_cnt_o,
  output logic                 busy_o
);
  state_t state, state_nxt;
  logic [BTS+OUT_W-1:0] head;
  logic [BTS-1:0] head_ts, diff;
  logic empty, full, push, due, load;
  wave_sched_fifo #(.NFIFO(NFIFO), .W(BTS+OUT_W)) u_fifo (
    .aclk(aclk),
    .areset(areset),
    .flush(flush),
    .push(push),
    .din(s_axis_tdata),
    .pop(load),
    .dout(head),
    .empty(empty),
    .full(full),
    .cnt(fifo_cnt_o)
  );
  assign s_axis_tready = !full && !areset;
  assign push = s_axis_tvalid && s_axis_tready && !flush;
  assign head_ts = head[BTS+OUT_W-1 -: BTS];
  // sign bit of the modular difference gives a wrap-safe "time has reached ts"
  assign diff = time_o - head_ts;
  assign due = busy_o && !empty && !diff[BTS-1];
  assign load = due && (!m_axis_tvalid || m_axis_tready) && !flush;
  always_ff @(posedge aclk)
    state <= areset ? ST_IDLE : state_nxt;
  always_comb
    state_nxt = stop ? ST_IDLE : start ? ST_RUN : state;
  always_comb
    busy_o = state == ST_RUN;
  always_ff @(posedge aclk) begin
    if (areset) begin
      time_o <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      late_cnt_o <= '0;
    end else begin
      if (start) time_o <= '0;
      else if (busy_o) time_o <= time_o + 1'b1;
      if (flush) m_axis_tvalid <= 1'b0;
      else if (load) m_axis_tvalid <= 1'b1;
      else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (load) m_axis_tdata <= head[OUT_W-1:0];
      if (load && time_o != head_ts && late_cnt_o != '1) late_cnt_o <= late_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_wave_sched.sv
// tb_axis_wave_sched: directed and random checks against a queue-based reference model
module tb_axis_wave_sched;
  localparam int NFIFO = 4;
  localparam int BTS = 10;
  localparam int DEPTH = 1 << NFIFO;
  localparam int unsigned MOD = 1 << BTS;
  logic aclk = 1'b0;
  logic areset, start, stop, flush;
  logic s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
  logic [BTS+79:0] s_axis_tdata;
  logic [79:0] m_axis_tdata;
  logic [BTS-1:0] time_o;
  logic [NFIFO:0] fifo_cnt_o;
  logic [15:0] late_cnt_o;
  logic busy_o;
  int n_chk = 0;
  int n_err = 0;
  logic [BTS+79:0] mq[$];
  bit m_run, m_ov;
  int unsigned m_t, m_late;
  logic [79:0] m_od;
  int unsigned xfers[$];

  axis_wave_sched #(.NFIFO(NFIFO), .BTS(BTS)) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop), .flush(flush),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .time_o(time_o), .fifo_cnt_o(fifo_cnt_o), .late_cnt_o(late_cnt_o), .busy_o(busy_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ts_of(input logic [BTS+79:0] e);
    return int'(e[BTS+79:80]);
  endfunction

  function automatic logic [BTS+79:0] mk(input int unsigned ts, input logic [31:0] addr);
    logic [BTS-1:0] t;
    t = BTS'(ts);
    return {t, 8'($urandom), 8'($urandom), 32'($urandom), addr};
  endfunction

  // reference: each edge, an entry leaves the queue head once its timestamp is no longer in the future
  task automatic step();
    bit rdy, due, ld;
    @(posedge aclk);
    rdy = !areset && mq.size() < DEPTH;
    due = 1'b0;
    if (m_run && mq.size() > 0) due = ((m_t - ts_of(mq[0])) % MOD) < MOD / 2;
    ld = due && (!m_ov || m_axis_tready) && !flush;
    if (areset) begin
      mq.delete();
      m_run = 0; m_ov = 0; m_t = 0; m_late = 0; m_od = '0;
    end else begin
      if (flush) begin
        mq.delete();
        m_ov = 0;
      end else begin
        if (ld) begin
          if (ts_of(mq[0]) != m_t && m_late < 65535) m_late++;
          m_od = mq.pop_front()[79:0];
          m_ov = 1;
        end else if (m_axis_tready) m_ov = 0;
        if (s_axis_tvalid && rdy) mq.push_back(s_axis_tdata);
      end
      if (start) m_t = 0;
      else if (m_run) m_t = (m_t + 1) % MOD;
      m_run = stop ? 1'b0 : start ? 1'b1 : m_run;
    end
    #1;
    chk("time", time_o, m_t);
    chk("busy", busy_o, m_run);
    chk("fifo_cnt", fifo_cnt_o, mq.size());
    chk("late", late_cnt_o, m_late);
    chk("m_valid", m_axis_tvalid, m_ov);
    if (m_ov) chk("m_data", m_axis_tdata, m_od);
    chk("s_ready", s_axis_tready, !areset && mq.size() < DEPTH);
    if (m_axis_tvalid && m_axis_tready) xfers.push_back(time_o);
  endtask

  task automatic quiet();
    areset = 0; start = 0; stop = 0; flush = 0;
    s_axis_tvalid = 0; s_axis_tdata = '0; m_axis_tready = 1;
  endtask

  task automatic do_reset();
    quiet();
    areset = 1;
    step();
    areset = 0;
    xfers.delete();
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int i;
    for (i = 0; i < lim && !m_axis_tvalid; i++) step();
    if (!m_axis_tvalid) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic push1(input logic [BTS+79:0] e);
    s_axis_tvalid = 1;
    s_axis_tdata = e;
    step();
    s_axis_tvalid = 0;
  endtask

  initial begin
    quiet();
    areset = 1;
    step();
    step();
    areset = 0;
    step();
    chk("rst_valid", m_axis_tvalid, 0);
    chk("rst_data", m_axis_tdata, 0);
    chk("rst_cnt", fifo_cnt_o, 0);
    chk("rst_time", time_o, 0);
    chk("rst_ready", s_axis_tready, 1);
    // single entry, minimum latency
    start = 1; step(); start = 0;
    push1(mk(10, 32'd5));
    wait_valid("t030", 40);
    chk("t030_time", time_o, 11);
    chk("t030_addr", m_axis_tdata[31:0], 5);
    chk("t030_late", late_cnt_o, 0);
    // equal timestamps issue back to back, two of them late
    do_reset();
    for (int i = 0; i < 3; i++) push1(mk(3, 32'(i)));
    start = 1; step(); start = 0;
    for (int i = 0; i < 12; i++) step();
    chk("t031_n", xfers.size(), 3);
    if (xfers.size() == 3) begin
      chk("t031_x0", xfers[0], 4);
      chk("t031_x1", xfers[1], 5);
      chk("t031_x2", xfers[2], 6);
    end
    chk("t031_late", late_cnt_o, 2);
    // fill to capacity while idle
    do_reset();
    s_axis_tvalid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      s_axis_tdata = mk(0, 32'(i));
      step();
    end
    chk("t032_ready", s_axis_tready, 0);
    chk("t032_cnt", fifo_cnt_o, 16);
    s_axis_tdata = mk(0, 32'h17);
    step(); step(); step();
    chk("t032_hold", fifo_cnt_o, 16);
    start = 1; step(); start = 0;
    for (int i = 0; i < 4; i++) step();
    s_axis_tvalid = 0;
    for (int i = 0; i < 24; i++) step();
    chk("t032_last", m_od[31:0], 32'h17);
    // timestamp just past the counter wrap
    do_reset();
    start = 1; step(); start = 0;
    for (int i = 0; i < 2000 && time_o != BTS'(MOD - 2); i++) step();
    chk("t033_pre", time_o, MOD - 2);
    push1(mk(1, 32'h33));
    wait_valid("t033", 20);
    chk("t033_time", time_o, 2);
    chk("t033_addr", m_axis_tdata[31:0], 32'h33);
    // flush with a stalled output
    do_reset();
    start = 1; step(); start = 0;
    m_axis_tready = 0;
    push1(mk(0, 32'h1));
    push1(mk(0, 32'h2));
    wait_valid("t034", 10);
    flush = 1; step(); flush = 0;
    chk("t034_valid", m_axis_tvalid, 0);
    chk("t034_cnt", fifo_cnt_o, 0);
    // reset while output valid and queue holding five
    do_reset();
    m_axis_tready = 0;
    for (int i = 0; i < 6; i++) push1(mk(0, 32'(i)));
    start = 1; step(); start = 0;
    wait_valid("t035", 10);
    chk("t035_pre", fifo_cnt_o, 5);
    areset = 1; step();
    chk("t035_valid", m_axis_tvalid, 0);
    chk("t035_data", m_axis_tdata, 0);
    chk("t035_cnt", fifo_cnt_o, 0);
    chk("t035_time", time_o, 0);
    chk("t035_busy", busy_o, 0);
    chk("t035_rdy0", s_axis_tready, 0);
    areset = 0; step();
    chk("t035_rdy1", s_axis_tready, 1);
    chk("t035_xfer", xfers.size(), 0);
    // random traffic
    quiet();
    for (int i = 0; i < 4000; i++) begin
      areset = $urandom_range(0, 799) == 0;
      start = $urandom_range(0, 99) == 0 || (!m_run && $urandom_range(0, 9) == 0);
      stop = $urandom_range(0, 149) == 0;
      flush = $urandom_range(0, 119) == 0;
      s_axis_tvalid = $urandom_range(0, 2) != 0;
      s_axis_tdata = mk((m_t + $urandom_range(0, 24) + MOD - 8) % MOD, $urandom);
      m_axis_tready = $urandom_range(0, 3) != 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
